// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side byte assembler.
//   DATA_BITS_DEFAULT : default frame data width
//   rx_asm_state_e    : assembler FSM states (IDLE, SHIFT, WAIT_STOP)
//   rx_entry_t        : one received byte plus its framing-error sideband
package uart_pkg;

    localparam int unsigned DATA_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_STOP = 2'd2
    } rx_asm_state_e;

    // Layout matches the {frame_err, data} word the assembler commits.
    typedef struct packed {
        logic                         frame_err;
        logic [DATA_BITS_DEFAULT-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_byte_assembler_if.sv
// Host-side valid/ready byte interface of rx_byte_assembler.
//   data_out           : received byte
//   data_out_frame_err : byte had a bad stop bit
//   data_out_valid     : data_out is valid
//   data_out_ready     : host accepts data_out this cycle
// Modports: master (assembler side), slave (host side).
interface rx_byte_assembler_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_frame_err;
    logic                 data_out_valid;
    logic                 data_out_ready;

    modport master (
        output data_out,
        output data_out_frame_err,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_frame_err,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   wr_en      : push wr_data; accepted when not full, or when full and
//                rd_en pops in the same cycle
//   wr_data    : entry to push
//   full       : DEPTH entries held
//   rd_en      : pop the head entry (ignored when empty)
//   rd_data    : head entry, valid whenever empty=0
//   empty      : no entries held
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = rd_en && !empty;
    // When full, a same-cycle pop frees the slot the push writes into.
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rx_byte_assembler.sv
// Receive byte assembler: shifts bit_detector's per-bit pulses LSB-first
// into a byte and hands completed bytes to the host over valid/ready.
// Build option: define RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry
// first-word fall-through FIFO instead of a single output register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   active_rx    : frame in data/stop phase
//   bit_ready    : one-cycle pulse, rx_bit holds the sampled data bit
//   rx_bit       : sampled data bit
//   done         : one-cycle pulse at end of stop bit
//   framing_err  : qualifies done, stop bit sampled low
//   host         : data_out / data_out_frame_err / data_out_valid / data_out_ready
//   overrun_err  : sticky, a completed byte was dropped (buffer full)
//   err_clear    : clears overrun_err (a same-cycle overrun wins)
//   busy         : frame assembly in progress
module rx_byte_assembler
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                active_rx,
    input  logic                bit_ready,
    input  logic                rx_bit,
    input  logic                done,
    input  logic                framing_err,
    rx_byte_assembler_if.master host,
    output logic                overrun_err,
    input  logic                err_clear,
    output logic                busy
);
    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_check
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    rx_asm_state_e        state;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 last_bit;
    logic                 commit;
    logic                 overrun_set;

    assign cnt_inc  = bit_cnt + 1'b1;
    assign last_bit = (cnt_inc == CNT_W'(DATA_BITS));
    assign commit   = (state == WAIT_STOP) && done;
    assign busy     = (state != IDLE);

    // bit_cnt is returned to zero on every exit to IDLE, so the IDLE branch
    // can reuse the same shift/count step for a bit arriving with active_rx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active_rx) begin
                        state <= SHIFT;
                        if (bit_ready) begin
                            shreg   <= {rx_bit, shreg[DATA_BITS-1:1]};
                            bit_cnt <= cnt_inc;
                            if (last_bit) begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                end
                SHIFT: begin
                    if (done || !active_rx) begin
                        // Short frame: partial byte is discarded silently.
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (bit_ready) begin
                        shreg   <= {rx_bit, shreg[DATA_BITS-1:1]};
                        bit_cnt <= cnt_inc;
                        if (last_bit) begin
                            state <= WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    // Extra bit_ready pulses are ignored; done commits,
                    // losing active_rx without done aborts.
                    if (done || !active_rx) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

`ifdef RX_FIFO_EN
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS:0]   head;

    assign pop = host.data_out_valid && host.data_out_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (commit),
        .wr_data ({framing_err, shreg}),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    assign host.data_out           = head[DATA_BITS-1:0];
    assign host.data_out_frame_err = head[DATA_BITS];
    assign host.data_out_valid     = !fifo_empty;
    assign overrun_set             = commit && fifo_full && !pop;
`else
    // The register is free when empty or being accepted this cycle, which
    // lets a commit replace an accepted byte without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host.data_out           <= '0;
            host.data_out_frame_err <= 1'b0;
            host.data_out_valid     <= 1'b0;
        end else if (commit && (!host.data_out_valid || host.data_out_ready)) begin
            host.data_out           <= shreg;
            host.data_out_frame_err <= framing_err;
            host.data_out_valid     <= 1'b1;
        end else if (host.data_out_valid && host.data_out_ready) begin
            host.data_out_valid     <= 1'b0;
        end
    end

    assign overrun_set = commit && host.data_out_valid && !host.data_out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_err <= 1'b0;
        end else if (overrun_set) begin
            overrun_err <= 1'b1;
        end else if (err_clear) begin
            overrun_err <= 1'b0;
        end
    end
endmodule

// File: doc/rx_byte_assembler.md
Name: rx_byte_assembler

Overview:
Receive-path stage directly downstream of bit_detector. It consumes the per-bit pulses (bit_ready/rx_bit) and the end-of-frame strobes (done/framing_err), shifts bits LSB-first into a byte, and presents each completed byte to the host over a valid/ready handshake. It flags framing errors per byte and reports overruns with a sticky flag.

Parameters:
DATA_BITS, 8, data bits per frame; must match bit_detector's frame length.
FIFO_DEPTH, 4, output buffer depth in entries; used only when RX_FIFO_EN is defined; power of two, minimum 2.

Ports:
clk  input  1  peripheral clock
rst_n  input  1  asynchronous active-low reset
active_rx  input  1  from bit_detector; high while a frame is in data/stop phase
bit_ready  input  1  from bit_detector; one-cycle pulse, rx_bit holds the sampled data bit
rx_bit  input  1  from bit_detector; sampled bit, valid when bit_ready=1
done  input  1  from bit_detector; one-cycle pulse at end of stop bit
framing_err  input  1  from bit_detector; qualifies done, stop bit sampled low
data_out  output  DATA_BITS  received byte
data_out_frame_err  output  1  sideband to data_out; byte had a bad stop bit
data_out_valid  output  1  data_out is valid
data_out_ready  input  1  host accepts data_out this cycle
overrun_err  output  1  sticky; a completed byte was dropped because the buffer was full
err_clear  input  1  clears overrun_err
busy  output  1  frame assembly in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on reset: data_out=0, data_out_frame_err=0, data_out_valid=0, overrun_err=0, busy=0. Shift register, bit counter and FSM also clear, with FSM=IDLE.
- Reset mid-frame discards the partial byte. A byte that was valid but not yet accepted is lost.
- FSM states:
  - IDLE -> SHIFT when active_rx=1. A bit_ready in that same cycle is captured.
  - SHIFT: on each bit_ready, shreg <= {rx_bit, shreg[DATA_BITS-1:1]} (LSB-first) and bit_cnt++. bit_cnt width is $clog2(DATA_BITS+1).
  - SHIFT -> WAIT_STOP on the bit_ready that makes bit_cnt == DATA_BITS.
  - SHIFT -> IDLE on done, or on active_rx=0, before DATA_BITS bits. This is a short frame: the byte is discarded with no output and no error.
  - WAIT_STOP: extra bit_ready pulses are ignored.
  - WAIT_STOP -> IDLE on done, which commits {shreg, framing_err}.
  - WAIT_STOP -> IDLE when active_rx=0 without done: abort, discard.
  - done in IDLE is ignored.
- Commit (single-register build):
  - Buffer free when data_out_valid=0, or data_out_valid & data_out_ready in the same cycle (pass-through replace).
  - If free, data_out / data_out_frame_err load and data_out_valid=1 on the next edge. Latency is done at edge N -> valid at N+1.
  - If not free, the new byte is dropped, the held byte is unchanged, and overrun_err sets on the next edge.
- Handshake:
  - data_out_valid falls after an edge where valid & ready, unless a same-cycle commit reloads it.
  - data_out and data_out_frame_err are stable while valid=1 and ready=0.
  - data_out_ready while valid=0 has no effect.
- overrun_err: set has priority over err_clear in the same cycle. Otherwise err_clear clears it on the next edge.
- A framing-error byte is still delivered, with data_out_frame_err=1. It is not counted as overrun.
- busy is combinational: (state != IDLE).

Optional Feature:
RX_FIFO_EN
- Defined:
  - The single output register is replaced by a FIFO of FIFO_DEPTH entries, each DATA_BITS+1 bits wide. data_out is the FIFO head, first-word fall-through.
  - Commit pushes; valid&ready pops.
  - Push and pop in the same cycle are both legal when full; the push succeeds.
  - Overrun only when full and not popping.
  - Commit-to-valid latency into an empty FIFO stays 1 cycle.
- Undefined: single-register behaviour as above. FIFO_DEPTH is unused.

Decomposition:
- Package uart_pkg holds the rx_asm_state_e enum (IDLE, SHIFT, WAIT_STOP), a DATA_BITS_DEFAULT constant, and a typedef rx_entry_t struct {frame_err, data}.
- One sub-module, sync_fifo (parameterised WIDTH and DEPTH, async active-low reset, first-word fall-through), instantiated only under RX_FIFO_EN.

Test Plan:
- Basic byte:
  - Stimulus: bits 1,0,1,0,0,1,0,1 via bit_ready, then done with framing_err=0, ready=1.
  - Response: data_out=8'hA5, frame_err=0, valid for 1 cycle at done+1.
- Framing error:
  - Stimulus: byte 8'h3C, done with framing_err=1.
  - Response: data_out=8'h3C, data_out_frame_err=1, overrun_err=0.
- Backpressure and overrun:
  - Stimulus: ready=0, frames 8'h11 then 8'h22.
  - Response: data_out stays 8'h11, overrun_err=1 after second done. err_clear then deasserts it.
  - Variant: with RX_FIFO_EN and FIFO_DEPTH=4, 4 frames give no overrun, the 5th sets it, and pops return 11,22,33,44.
- Same-cycle accept and commit:
  - Stimulus: 8'h55 held, ready=1 in the cycle done for 8'hAA arrives.
  - Response: valid stays 1, data_out=8'hAA next cycle, no overrun.
- Short frame and abort:
  - Stimulus: 3 bits then active_rx=0. Separately, 8 bits with no done and active_rx dropping.
  - Response: no valid, FSM IDLE, busy=0, overrun_err=0.
- Async reset mid-frame:
  - Stimulus: rst_n low after 4 bits, between clock edges.
  - Response: all outputs 0 immediately. The next full frame 8'hF0 is received correctly.
